// File: rtl/lfsr_gen.sv
// lfsr_gen
// Parametrised pseudo-random sequence generator with run-time selection of
// Fibonacci or Galois form, seed load, step enable, all-zero lockup guard and
// on-chip period measurement.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         advance the state one step this cycle
//   load       load seed_in this cycle (priority over en)
//   seed_in    value to load (zero is replaced by SEED)
//   mode       0 = Fibonacci, 1 = Galois
//   rnd        current state (registered)
//   rnd_valid  one-cycle pulse: rnd changed on the last edge
//   lockup     one-cycle pulse: an all-zero state/seed was replaced by SEED
//   wrap       one-cycle pulse: a step returned the state to its start value
//   period     last measured sequence period in steps
module lfsr_gen #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] FIB_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] GAL_TAPS = 8'h1D,
  parameter logic [WIDTH-1:0] SEED     = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  // Value the current sequence is measured against, steps taken since that
  // value was captured, and the mode used by the previous edge.
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] count;
  logic             mode_q;

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] step_next;
  logic             mode_chg;
  logic [WIDTH-1:0] eff_start;
  logic [WIDTH-1:0] eff_count;
  logic [WIDTH-1:0] count_inc;

  // Both successor states are always computed; the mode input present at the
  // edge picks which one a step uses, so a mode switch takes effect on the
  // very edge where it is first seen.
  assign fib_fb    = ^(rnd & FIB_TAPS);
  assign fib_next  = {rnd[WIDTH-2:0], fib_fb};
  assign gal_next  = {rnd[WIDTH-2:0], 1'b0} ^ (rnd[WIDTH-1] ? GAL_TAPS : '0);
  assign step_next = mode ? gal_next : fib_next;

  // A mode change restarts period measurement from the pre-step state. When a
  // step happens on the same edge, it is measured against that fresh start
  // with a zero count, so the wrap lands exactly one full period later.
  assign mode_chg  = (mode != mode_q);
  assign eff_start = mode_chg ? rnd : start;
  assign eff_count = mode_chg ? '0 : count;

  // The step counter sticks at all-ones instead of rolling over, so a
  // sequence longer than the counter can represent reports the maximum.
  assign count_inc = (eff_count == '1) ? eff_count : eff_count + WIDTH'(1);

  // Single state register block. Pulses default low every edge so each one
  // lasts exactly the cycle after its cause. Priority is load, then the
  // all-zero guard, then mode change and step. A load does not touch mode_q;
  // any pending mode change is picked up on the following edge, which only
  // re-captures start from the freshly loaded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd       <= SEED;
      start     <= SEED;
      count     <= '0;
      period    <= '0;
      mode_q    <= 1'b0;
      rnd_valid <= 1'b0;
      lockup    <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      rnd_valid <= 1'b0;
      lockup    <= 1'b0;
      wrap      <= 1'b0;
      if (load) begin
        if (seed_in == '0) begin
          rnd    <= SEED;
          start  <= SEED;
          lockup <= 1'b1;
        end else begin
          rnd   <= seed_in;
          start <= seed_in;
        end
        count     <= '0;
        rnd_valid <= 1'b1;
      end else if (rnd == '0) begin
        rnd       <= SEED;
        start     <= SEED;
        count     <= '0;
        lockup    <= 1'b1;
        rnd_valid <= 1'b1;
      end else begin
        if (mode_chg) begin
          mode_q <= mode;
        end
        if (en) begin
          rnd       <= step_next;
          rnd_valid <= 1'b1;
          start     <= eff_start;
          if (step_next == eff_start) begin
            wrap   <= 1'b1;
            period <= count_inc;
            count  <= '0;
          end else begin
            count <= count_inc;
          end
        end else if (mode_chg) begin
          start <= rnd;
          count <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen
// Directed self-checking bench for lfsr_gen with default parameters
// (8-bit, Fibonacci taps 0xB8, Galois taps 0x1D, seed 0x01).
module tb_lfsr_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] seed_in;
  logic       mode;
  logic [7:0] rnd;
  logic       rnd_valid;
  logic       lockup;
  logic       wrap;
  logic [7:0] period;

  int checks   = 0;
  int failures = 0;

  lfsr_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .seed_in   (seed_in),
    .mode      (mode),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .lockup    (lockup),
    .wrap      (wrap),
    .period    (period)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Galois reference: multiply by x modulo x^8 + x^4 + x^3 + x^2 + 1.
  function automatic logic [7:0] galModel(input logic [7:0] r);
    logic [8:0] t;
    t = {r, 1'b0};
    if (t[8]) t = t ^ 9'h11D;
    return t[7:0];
  endfunction

  // Fibonacci reference: shift left, feed back XOR of bits 7, 5, 4 and 3.
  function automatic logic [7:0] fibModel(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
  endfunction

  // Drive one cycle of inputs just after an edge, then wait until just after
  // the next edge so outputs are sampled well away from the clock.
  task automatic applyStimulus(input logic l, input logic e, input logic m,
                               input logic [7:0] s);
    load    = l;
    en      = e;
    mode    = m;
    seed_in = s;
    @(posedge clk);
    #1;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Synchronous-looking reset pulse taken between edges.
  task automatic doReset();
    rst_n = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Directed sequence of all test steps.
  initial begin
    logic [7:0] exp_rnd;
    logic [7:0] gal_vec [9];
    logic [7:0] fib_vec [3];
    bit         seen [256];
    int         wraps;
    int         repeats;

    gal_vec = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
    fib_vec = '{8'h01, 8'h02, 8'h04};

    rst_n   = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    mode    = 1'b0;
    seed_in = 8'h00;

    // Reset then hold
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rnd", rnd, 8'h01);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("hold_rnd", rnd, 8'h01);
    checkOutput("hold_rnd_valid", rnd_valid, 1'b0);
    checkOutput("hold_wrap", wrap, 1'b0);
    checkOutput("hold_lockup", lockup, 1'b0);
    checkOutput("hold_period", period, 8'h00);

    // Galois sequence
    $display("[TB] Galois sequence");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h01);
    checkOutput("gal_load_rnd", rnd, 8'h01);
    checkOutput("gal_load_valid", rnd_valid, 1'b1);
    checkOutput("gal_load_lockup", lockup, 1'b0);
    exp_rnd = 8'h01;
    wraps   = 0;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
      exp_rnd = galModel(exp_rnd);
      if (i <= 9) checkOutput($sformatf("gal_hand%0d", i), rnd, gal_vec[i-1]);
      checkOutput($sformatf("gal_step%0d", i), rnd, exp_rnd);
      if (i < 255) wraps += int'(wrap);
    end
    checkOutput("gal_early_wraps", wraps, 0);
    checkOutput("gal_wrap", wrap, 1'b1);
    checkOutput("gal_wrap_rnd", rnd, 8'h01);
    checkOutput("gal_period", period, 8'hFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    checkOutput("gal_wrap_clear", wrap, 1'b0);
    checkOutput("gal_after_wrap", rnd, 8'h02);

    // Fibonacci sequence from a fresh reset so period starts at zero
    $display("[TB] Fibonacci sequence");
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h80);
    checkOutput("fib_load_rnd", rnd, 8'h80);
    foreach (seen[k]) seen[k] = 1'b0;
    seen[8'h80] = 1'b1;
    exp_rnd = 8'h80;
    wraps   = 0;
    repeats = 0;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      exp_rnd = fibModel(exp_rnd);
      if (i <= 3) checkOutput($sformatf("fib_hand%0d", i), rnd, fib_vec[i-1]);
      checkOutput($sformatf("fib_step%0d", i), rnd, exp_rnd);
      if (i < 255) begin
        wraps += int'(wrap);
        if (seen[rnd]) repeats++;
        seen[rnd] = 1'b1;
      end
    end
    checkOutput("fib_repeats", repeats, 0);
    checkOutput("fib_early_wraps", wraps, 0);
    checkOutput("fib_wrap", wrap, 1'b1);
    checkOutput("fib_wrap_rnd", rnd, 8'h80);
    checkOutput("fib_period", period, 8'hFF);

    // Zero-seed lockup
    $display("[TB] Zero-seed lockup");
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("lock_rnd", rnd, 8'h01);
    checkOutput("lock_pulse", lockup, 1'b1);
    checkOutput("lock_valid", rnd_valid, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("lock_step_rnd", rnd, 8'h02);
    checkOutput("lock_pulse_clear", lockup, 1'b0);

    // Load and enable together
    $display("[TB] Priority");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
    checkOutput("prio_rnd", rnd, 8'h5A);
    checkOutput("prio_valid", rnd_valid, 1'b1);
    checkOutput("prio_wrap", wrap, 1'b0);
    exp_rnd = 8'h5A;
    wraps   = 0;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      exp_rnd = fibModel(exp_rnd);
      checkOutput($sformatf("prio_step%0d", i), rnd, exp_rnd);
      if (i < 255) wraps += int'(wrap);
    end
    checkOutput("prio_early_wraps", wraps, 0);
    checkOutput("prio_wrap_end", wrap, 1'b1);
    checkOutput("prio_period", period, 8'hFF);

    // Mode switch mid-sequence, then reset during the wrap pulse
    $display("[TB] Mode switch and reset");
    doReset();
    exp_rnd = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      exp_rnd = fibModel(exp_rnd);
    end
    checkOutput("sw_pre_rnd", rnd, exp_rnd);
    wraps = 0;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
      exp_rnd = galModel(exp_rnd);
      checkOutput($sformatf("sw_step%0d", i), rnd, exp_rnd);
      if (i < 255) wraps += int'(wrap);
    end
    checkOutput("sw_early_wraps", wraps, 0);
    checkOutput("sw_wrap", wrap, 1'b1);
    checkOutput("sw_period", period, 8'hFF);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    checkOutput("rst_wrap", wrap, 1'b0);
    checkOutput("rst_rnd", rnd, 8'h01);
    checkOutput("rst_valid", rnd_valid, 1'b0);
    checkOutput("rst_period", period, 8'h00);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_hold_rnd", rnd, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
